// File: rtl/output_buffer_pkg.sv
// output_buffer_pkg: shared sizes and drain FSM states for the output buffer
package output_buffer_pkg;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;
endpackage

// File: rtl/ob_regfile.sv
// ob_regfile: result storage with per-entry valid bits, one write, one read, one clear port
module ob_regfile import output_buffer_pkg::*; #(
  parameter int DEPTH = output_buffer_pkg::DEPTH,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DEPTH-1:0]  valid_nxt,
  output logic              overwrite
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  assign rd_data = mem_q[rd_addr];
  assign rd_valid = valid_q[rd_addr];
  assign valid_nxt = valid_d;
  // a write landing on an entry being fetched out this cycle is a refill, not an overwrite
  assign overwrite = wr_en && valid_q[wr_addr] && !(clr_en && clr_addr == wr_addr);
  // next valid vector: fetch clears, write sets and wins on the same entry
  always_comb begin
    valid_d = valid_q;
    if (clr_en) valid_d[clr_addr] = 1'b0;
    if (wr_en) valid_d[wr_addr] = 1'b1;
  end
  // valid bits are reset, data is not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else valid_q <= valid_d;
  end
  // data storage
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end
endmodule

// File: rtl/output_buffer.sv
// output_buffer: stores accumulator results and streams a wrapped range out over valid/ready
module output_buffer import output_buffer_pkg::*; #(
  parameter int DEPTH = output_buffer_pkg::DEPTH,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              drain_start,
  input  logic [ADDR_W-1:0] drain_base,
  input  logic [CNT_W-1:0]  drain_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              drain_done,
  output logic [CNT_W-1:0]  fill_count,
  output logic              err
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, out_addr_q, out_addr_d, rd_addr;
  logic [CNT_W-1:0] rem_q, rem_d, fill_q, fill_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, rd_data;
  logic out_valid_q, out_valid_d, err_q, err_d, clr_en, rd_valid, overwrite;
  logic [DEPTH-1:0] valid_nxt;
  ob_regfile #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rf (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_en(clr_en), .clr_addr(rd_addr), .valid_nxt(valid_nxt), .overwrite(overwrite)
  );
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_addr = out_addr_q;
  assign busy = state_q != IDLE;
  assign drain_done = state_q == DONE;
  assign fill_count = fill_q;
  assign err = err_q;
  assign fill_d = CNT_W'($countones(valid_nxt));
  // drain FSM: in STREAM the read port looks one entry ahead so an accepted beat can be refilled at once
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    rem_d = rem_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    clr_en = 1'b0;
    rd_addr = (state_q == STREAM) ? ptr_q + 1'b1 : ptr_q;
    err_d = err_q | overwrite | (state_q == IDLE && drain_start && drain_count == '0);
    case (state_q)
      IDLE: if (drain_start && drain_count != '0) begin
        ptr_d = drain_base;
        rem_d = drain_count;
        state_d = FETCH;
      end
      FETCH: if (rd_valid) begin
        clr_en = 1'b1;
        out_valid_d = 1'b1;
        out_data_d = rd_data;
        out_addr_d = rd_addr;
        state_d = STREAM;
      end
      STREAM: if (out_ready) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          out_valid_d = 1'b0;
          state_d = DONE;
        end else begin
          ptr_d = rd_addr;
          clr_en = rd_valid;
          out_valid_d = rd_valid;
          out_data_d = rd_valid ? rd_data : out_data_q;
          out_addr_d = rd_valid ? rd_addr : out_addr_q;
          state_d = rd_valid ? STREAM : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // control and output registers, all cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      rem_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_addr_q <= '0;
      fill_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      rem_q <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      fill_q <= fill_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 32-bit result entries.
REQ-002 SHALL have parameter DATA_W, default 32, entry width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  accumulator store strobe (output_buffer_enable).
REQ-006 SHALL have port wr_addr  input  4  write entry index.
REQ-007 SHALL have port wr_data  input  DATA_W  accumulator result.
REQ-008 SHALL have port drain_start  input  1  one-cycle request to stream entries out.
REQ-009 SHALL have port drain_base  input  4  first entry index of drain.
REQ-010 SHALL have port drain_count  input  5  number of entries to drain, 1..16.
REQ-011 SHALL have port out_valid  output  1  out_data/out_addr valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the beat when high with out_valid.
REQ-013 SHALL have port out_data  output  DATA_W  streamed entry.
REQ-014 SHALL have port out_addr  output  4  index of streamed entry.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port drain_done  output  1  one-cycle pulse after the last beat is accepted.
REQ-017 SHALL have port fill_count  output  5  number of entries with valid bit set.
REQ-018 SHALL have port err  output  1  sticky: overwrite of a valid entry, or drain_count of 0.

Function
REQ-019 SHALL keep DEPTH data registers plus one valid bit per entry; a write stores wr_data and sets valid[wr_addr] on the clock edge.
REQ-020 SHALL implement FSM IDLE, FETCH, STREAM, DONE.
REQ-021 IDLE: drain_start with drain_count 1..16 -> latch ptr=drain_base, remaining=drain_count, go to FETCH; drain_start with drain_count 0 -> set err, stay IDLE; drain_start outside IDLE ignored.
REQ-022 FETCH: if valid[ptr] is set, register mem[ptr] into out_data, ptr into out_addr, clear valid[ptr], assert out_valid, go to STREAM; otherwise wait in FETCH with out_valid low.
REQ-023 STREAM: out_data/out_addr SHALL stay stable while out_valid && !out_ready.
REQ-024 STREAM handshake: decrement remaining; if remaining becomes 0 -> DONE with out_valid low; else ptr=ptr+1 mod 16, and if valid[next] is set load it the same cycle (one beat per clock), otherwise drop out_valid and go to FETCH.
REQ-025 Drain address SHALL wrap from 15 to 0.
REQ-026 DONE: drain_done high for exactly one cycle, then IDLE.
REQ-027 Latency: first out_valid SHALL be 2 cycles after drain_start when entry drain_base is already valid.
REQ-028 Write to an entry whose valid bit is already set SHALL overwrite the data and set err.
REQ-029 Write and fetch-clear on the same entry in one cycle: the fetched beat carries old data, the new data is stored, valid stays set, err not set.
REQ-030 fill_count SHALL be registered, equal to the popcount of valid bits after each edge.

Reset
REQ-031 rst SHALL asynchronously force IDLE, all valid bits 0, out_valid 0, out_data 0, out_addr 0, busy 0, drain_done 0, fill_count 0, err 0.
REQ-032 Data registers SHALL NOT be reset; reset mid-drain SHALL abort with no drain_done pulse.

Structure
REQ-033 Package output_buffer_pkg SHALL hold DEPTH, ADDR_W=4, CNT_W=5, and the FSM state enum.
REQ-034 Storage plus valid bits SHALL be one sub-module ob_regfile (one write port, one read port, one clear port); FSM and counters stay in output_buffer.

Verification
REQ-035 Write 0x3F800000 to addr 2, drain base 2 count 1, out_ready=1 -> out_valid 2 cycles later with data 0x3F800000 addr 2, drain_done next cycle, fill_count 1->0.
REQ-036 Fill 16 entries, drain base 14 count 4, out_ready=1 -> addrs 14,15,0,1 on consecutive cycles, fill_count 16->12.
REQ-037 out_ready held low 3 cycles during beat 1 -> out_data/out_addr unchanged across the stall, no beat lost or duplicated.
REQ-038 Drain base 5 count 2 with entry 5 empty -> busy=1, out_valid=0 until write to 5, then beat 5 on the cycle after the write.
REQ-039 Write addr 7 twice without drain -> err=1 sticky, second value streamed; drain_start with count 0 -> err=1, state stays IDLE.
REQ-040 Assert rst during STREAM -> out_valid, busy, fill_count, err 0 immediately, no drain_done pulse.
